div_share_ctrl: RTL and testbench
=================================

DIV_SHARE_CTRL -- requirements
Module: div_share_ctrl

Interface
REQ-001 SHALL have parameter DW, 8, dividend/quotient/remainder width.
REQ-002 SHALL have parameter BW, 4, divisor width.
REQ-003 SHALL have parameter ITERS, DW, non-restoring iterations per divide.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 req0_valid/req1_valid  in  1  requester N has an operation pending.
REQ-007 req0_ready/req1_ready  out  1  operation from requester N accepted this cycle when valid&ready.
REQ-008 req0_a/req1_a  in  DW  dividend; req0_b/req1_b  in  BW  divisor, unsigned.
REQ-009 rsp_valid  out  1  response available; rsp_ready  in  1  consumer accepts response.
REQ-010 rsp_id  out  1  index of requester that issued the operation.
REQ-011 rsp_quot  out  DW  quotient; rsp_rem  out  DW  remainder; rsp_dbz  out  1  divide-by-zero flag.
REQ-012 busy  out  1  high in every state except IDLE.

Function
REQ-013 SHALL share one iterative non-restoring divide datapath between two requesters, one operation outstanding at a time.
REQ-014 FSM states SHALL be IDLE, ITER, CORR, DONE.
REQ-015 IDLE: reqN_ready = (state==IDLE) & grant==N; ready is combinational from valid and the round-robin pointer.
REQ-016 Arbitration SHALL be round-robin: single valid requester wins; both valid -> the one not granted last; pointer after reset favours req0.
REQ-017 On accept SHALL latch A, B, id; pointer updates to granted id; partial remainder cleared; iteration counter = 0.
REQ-018 Accept with B!=0 -> ITER; accept with B==0 -> DONE directly, rsp_dbz=1, rsp_quot=all-ones, rsp_rem=A.
REQ-019 ITER SHALL perform exactly one non-restoring step per cycle: shift {rem,quot} left 1; rem sign=0 -> subtract zero-extended B, else add; new quot LSB = ~rem sign.
REQ-020 After ITERS ITER cycles -> CORR; CORR SHALL add B back if remainder negative, else hold; -> DONE.
REQ-021 Latency SHALL be ITERS+2 cycles from accept edge to rsp_valid high (10 for DW=8), fixed for every B!=0.
REQ-022 For B!=0 results SHALL equal A/B and A%B (unsigned, floor).
REQ-023 DONE: rsp_valid=1; rsp_* stable until rsp_valid&rsp_ready; then -> IDLE; no accept in the handshake cycle.
REQ-024 Requests arriving while busy SHALL wait (ready low); operands need not be stable before accept.
REQ-025 rsp_ready asserted outside DONE SHALL have no effect.

Reset
REQ-026 rst SHALL force state=IDLE, rsp_valid=0, rsp_id=0, rsp_quot=0, rsp_rem=0, rsp_dbz=0, busy=0, pointer=req0-priority, counter=0, immediately and asynchronously.
REQ-027 Reset mid-operation SHALL abandon the operation with no response emitted; first post-reset cycle in IDLE accepts normally.

Structure
REQ-028 Shared package div_ctrl_pkg SHALL hold the state enum, DW/BW/ITERS defaults and the divide-by-zero quotient constant.
REQ-029 One combinational sub-module div_nr_step (one shift/add-sub step, width-parameterised) SHALL be instantiated once and reused by CORR via an add-only control.
REQ-030 Datapath registers: remainder DW+1 bits signed, quotient DW bits, counter clog2(ITERS+1) bits.

Verification
REQ-031 req0 A=200,B=7 alone -> accept cycle 0, rsp_valid cycle 10, quot=28, rem=4, id=0, dbz=0.
REQ-032 Boundary sweep A=255,B=15 -> 17/0; A=7,B=9 -> 0/7; A=0,B=1 -> 0/0; A=255,B=1 -> 255/0.
REQ-033 req1 A=100,B=0 -> rsp_valid cycle after accept, dbz=1, quot=8'hFF, rem=100, id=1.
REQ-034 Both valid from reset, held -> req0 served first, then req1, then req0 alternately; no starvation over 20 operations.
REQ-035 rsp_ready low for 5 cycles in DONE -> rsp_* stable, both ready low, next accept only after handshake cycle.
REQ-036 rst pulsed at ITER cycle 4 -> all outputs reset values at once, no rsp_valid; new request completes correctly afterwards.

Source files
------------

// File: rtl/div_ctrl_pkg.sv
// Shared types and defaults for the two-requester shared divider.
package div_ctrl_pkg;
  localparam int DW_DEF    = 8;
  localparam int BW_DEF    = 4;
  localparam int ITERS_DEF = DW_DEF;

  // Quotient reported on divide-by-zero; sliced to DW at the use site.
  localparam logic [31:0] DBZ_QUOT = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_CORR,
    S_DONE
  } state_t;
endpackage

// File: rtl/div_nr_step.sv
// One non-restoring divide step; add_only turns it into the final remainder fix-up.
module div_nr_step #(
  parameter int DW = 8,
  parameter int BW = 4
) (
  input  logic signed [DW:0]   rem,
  input  logic        [DW-1:0] quot,
  input  logic        [BW-1:0] b,
  input  logic                 add_only,
  output logic signed [DW:0]   rem_nxt,
  output logic        [DW-1:0] quot_nxt
);
  logic [DW:0] sh;
  logic [DW:0] bz;

  // Next dividend bit shifts out of the quotient MSB into the remainder LSB.
  assign sh = {rem[DW-1:0], quot[DW-1]};
  assign bz = {{(DW+1-BW){1'b0}}, b};

  always_comb begin
    rem_nxt  = rem;
    quot_nxt = quot;
    if (add_only) begin
      rem_nxt = rem + bz;
    end else begin
      rem_nxt  = rem[DW] ? sh + bz : sh - bz;
      quot_nxt = {quot[DW-2:0], ~rem_nxt[DW]};
    end
  end
endmodule

// File: rtl/div_share_ctrl.sv
// Round-robin shared iterative divider: two requesters, one operation in flight.
module div_share_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int BW    = BW_DEF,
  parameter int ITERS = DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [DW-1:0] req0_a,
  input  logic [BW-1:0] req0_b,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [DW-1:0] req1_a,
  input  logic [BW-1:0] req1_b,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [DW-1:0] rsp_quot,
  output logic [DW-1:0] rsp_rem,
  output logic          rsp_dbz,
  output logic          busy
);
  localparam int CW = $clog2(ITERS + 1);
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  state_t             state;
  logic               last;
  logic [CW-1:0]      cnt;
  logic signed [DW:0] rem;
  logic [DW-1:0]      quot;
  logic [BW-1:0]      b;
  logic signed [DW:0] rem_nxt;
  logic [DW-1:0]      quot_nxt;

  logic          idle, gnt1, accept;
  logic [DW-1:0] acc_a;
  logic [BW-1:0] acc_b;

  // last holds the previously granted id; reset to 1 so req0 wins the first tie.
  assign idle       = (state == S_IDLE);
  assign gnt1       = req1_valid & (~req0_valid | ~last);
  assign req1_ready = idle & gnt1;
  assign req0_ready = idle & req0_valid & ~gnt1;
  assign accept     = req0_ready | req1_ready;
  assign acc_a      = gnt1 ? req1_a : req0_a;
  assign acc_b      = gnt1 ? req1_b : req0_b;

  div_nr_step #(.DW(DW), .BW(BW)) u_step (
    .rem      (rem),
    .quot     (quot),
    .b        (b),
    .add_only (state == S_CORR),
    .rem_nxt  (rem_nxt),
    .quot_nxt (quot_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      last      <= 1'b1;
      cnt       <= '0;
      rem       <= '0;
      quot      <= '0;
      b         <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_quot  <= '0;
      rsp_rem   <= '0;
      rsp_dbz   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          last   <= gnt1;
          rsp_id <= gnt1;
          b      <= acc_b;
          quot   <= acc_a;
          rem    <= '0;
          cnt    <= '0;
          busy   <= 1'b1;
          if (acc_b == '0) begin
            rsp_dbz   <= 1'b1;
            rsp_quot  <= DBZ_QUOT[DW-1:0];
            rsp_rem   <= acc_a;
            rsp_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            rsp_dbz <= 1'b0;
            state   <= S_ITER;
          end
        end
        S_ITER: begin
          rem  <= rem_nxt;
          quot <= quot_nxt;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) state <= S_CORR;
        end
        S_CORR: begin
          if (rem[DW]) rem <= rem_nxt;
          rsp_quot  <= quot;
          rsp_rem   <= rem[DW] ? rem_nxt[DW-1:0] : rem[DW-1:0];
          rsp_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_share_ctrl.sv
// Bench for div_share_ctrl: fixed vectors, random ops vs. arithmetic model, arbitration and reset sequences.
module tb_div_share_ctrl;
  localparam int DW = 8;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [DW-1:0] req0_a = '0, req1_a = '0;
  logic [BW-1:0] req0_b = '0, req1_b = '0;
  logic          rsp_valid, rsp_id, rsp_dbz, busy;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_quot, rsp_rem;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  div_share_ctrl #(.DW(DW), .BW(BW), .ITERS(DW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_quot(rsp_quot), .rsp_rem(rsp_rem), .rsp_dbz(rsp_dbz), .busy(busy)
  );

  typedef struct {
    bit            id;
    logic [DW-1:0] a;
    logic [BW-1:0] b;
    logic [DW-1:0] q;
    logic [DW-1:0] r;
    bit            dbz;
    int            lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d @%0t", name, act, exp, $time);
    end
  endtask

  // Reference: unsigned floor division, all-ones quotient and A as remainder on B==0.
  task automatic ref_div(input int a, input int b, output int q, output int r, output int d);
    if (b == 0) begin q = 255; r = a; d = 1; end
    else begin q = a / b; r = a % b; d = 0; end
  endtask

  task automatic drive(input bit id, input bit v, input logic [DW-1:0] a, input logic [BW-1:0] b);
    if (id) begin req1_valid = v; req1_a = a; req1_b = b; end
    else    begin req0_valid = v; req0_a = a; req0_b = b; end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Issue one op from requester id, check latency/results, optionally stall the response.
  task automatic run_op(input string tag, input bit id, input logic [DW-1:0] a, input logic [BW-1:0] b,
                        input int eq, input int er, input int ed, input int elat, input int hold);
    bit ok = 0;
    int lat = 0;
    logic [DW-1:0] q0, r0;
    @(negedge clk);
    drive(id, 1'b1, a, b);
    for (int i = 0; i < 60; i++) begin
      #1;
      if (id ? req1_ready : req0_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      chk({tag, "_ready_timeout"}, 0, 1);
      drive(id, 1'b0, '0, '0);
      return;
    end
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        drive(id, 1'b0, '0, '0);
        chk({tag, "_busy"}, busy, 1);
      end
    end while (!rsp_valid && lat < 40);
    chk({tag, "_latency"}, lat, elat);
    chk({tag, "_id"}, rsp_id, id);
    chk({tag, "_quot"}, rsp_quot, eq);
    chk({tag, "_rem"}, rsp_rem, er);
    chk({tag, "_dbz"}, rsp_dbz, ed);
    q0 = rsp_quot;
    r0 = rsp_rem;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < hold; i++) begin
      #1;
      chk({tag, "_hold_valid"}, rsp_valid, 1);
      chk({tag, "_hold_quot"}, rsp_quot, q0);
      chk({tag, "_hold_rem"}, rsp_rem, r0);
      chk({tag, "_hold_ready"}, {req0_ready, req1_ready}, 0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    chk({tag, "_hs_ready"}, {req0_ready, req1_ready}, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, "_rsp_drop"}, rsp_valid, 0);
    chk({tag, "_idle_busy"}, busy, 0);
  endtask

  initial begin
    vec_t vecs[8];
    int q, r, d;
    bit exp_id, last;
    int lat, served0, served1;
    bit no_rsp;
    logic [DW-1:0] pa [2];
    logic [BW-1:0] pb [2];

    vecs[0] = '{0, 8'd200, 4'd7,  8'd28,  8'd4,   0, 10};
    vecs[1] = '{0, 8'd255, 4'd15, 8'd17,  8'd0,   0, 10};
    vecs[2] = '{1, 8'd7,   4'd9,  8'd0,   8'd7,   0, 10};
    vecs[3] = '{0, 8'd0,   4'd1,  8'd0,   8'd0,   0, 10};
    vecs[4] = '{1, 8'd255, 4'd1,  8'd255, 8'd0,   0, 10};
    vecs[5] = '{1, 8'd100, 4'd0,  8'hFF,  8'd100, 1, 1};
    vecs[6] = '{0, 8'd128, 4'd3,  8'd42,  8'd2,   0, 10};
    vecs[7] = '{1, 8'd1,   4'd15, 8'd0,   8'd1,   0, 10};

    #2;
    chk("reset_outputs", {rsp_valid, rsp_id, rsp_dbz, busy, req0_ready, req1_ready}, 0);
    chk("reset_quot", rsp_quot, 0);
    chk("reset_rem", rsp_rem, 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) run_op($sformatf("vec%0d", i), vecs[i].id, vecs[i].a, vecs[i].b,
                             vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].lat, 0);

    // Response stalled for 5 cycles with both requesters waiting.
    run_op("stall", 0, 8'd50, 4'd6, 8, 2, 0, 10, 5);

    for (int k = 0; k < 40; k++) begin
      logic [DW-1:0] a = DW'($urandom_range(0, 255));
      logic [BW-1:0] b = BW'($urandom_range(0, 15));
      ref_div(int'(a), int'(b), q, r, d);
      run_op($sformatf("rnd%0d", k), bit'($urandom_range(0, 1)), a, b, q, r, d, d ? 1 : 10,
             $urandom_range(0, 2));
    end

    // Both requesters held valid: service must alternate, starting with req0.
    do_reset();
    last = 1'b1;
    served0 = 0;
    served1 = 0;
    for (int j = 0; j < 2; j++) begin
      pa[j] = DW'($urandom_range(0, 255));
      pb[j] = BW'($urandom_range(1, 15));
    end
    for (int k = 0; k < 20; k++) begin
      drive(0, 1'b1, pa[0], pb[0]);
      drive(1, 1'b1, pa[1], pb[1]);
      #1;
      exp_id = ~last;
      chk($sformatf("rr%0d_ready", k), {req1_ready, req0_ready}, exp_id ? 2'b10 : 2'b01);
      ref_div(int'(pa[exp_id]), int'(pb[exp_id]), q, r, d);
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
        if (lat == 1) begin
          pa[exp_id] = DW'($urandom_range(0, 255));
          pb[exp_id] = BW'($urandom_range(1, 15));
          drive(exp_id, 1'b1, pa[exp_id], pb[exp_id]);
        end
      end while (!rsp_valid && lat < 40);
      chk($sformatf("rr%0d_latency", k), lat, 10);
      chk($sformatf("rr%0d_id", k), rsp_id, exp_id);
      chk($sformatf("rr%0d_quot", k), rsp_quot, q);
      chk($sformatf("rr%0d_rem", k), rsp_rem, r);
      if (rsp_id) served1++; else served0++;
      last = exp_id;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("rr_served0", served0, 10);
    chk("rr_served1", served1, 10);

    // Reset in the middle of an iteration abandons the op.
    @(negedge clk);
    drive(1, 1'b1, 8'd200, 4'd7);
    #1;
    chk("abort_accept", req1_ready, 1);
    @(negedge clk);
    drive(1, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    chk("abort_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    chk("abort_outputs", {rsp_valid, rsp_id, rsp_dbz, busy}, 0);
    chk("abort_quot", rsp_quot, 0);
    chk("abort_rem", rsp_rem, 0);
    @(negedge clk);
    rst = 1'b0;
    no_rsp = 1'b1;
    repeat (15) begin
      @(negedge clk);
      if (rsp_valid || busy) no_rsp = 1'b0;
    end
    chk("abort_no_rsp", no_rsp, 1);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("abort_ptr_reset", {req1_ready, req0_ready}, 2'b01);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    run_op("post_reset", 1, 8'd77, 4'd5, 15, 2, 0, 10, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
